// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: header op codes, header
// field positions, FSM state encoding and the load range check.
package program_loader_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_IMEM = 2'b00,
    OP_LOAD_DMEM = 2'b01,
    OP_RUN       = 2'b10,
    OP_HALT      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam int unsigned HDR_OP_HI     = 31;
  localparam int unsigned HDR_OP_LO     = 30;
  localparam int unsigned HDR_CNT_HI    = 29;
  localparam int unsigned HDR_CNT_LO    = 16;
  localparam int unsigned HDR_BASE_HI   = 15;
  localparam int unsigned HDR_BASE_LO   = 0;
  localparam int unsigned HDR_BUDGET_HI = 29;
  localparam int unsigned HDR_BUDGET_LO = 0;

  localparam int unsigned CNT_W    = 14;
  localparam int unsigned BASE_W   = 16;
  localparam int unsigned BUDGET_W = 30;

  // True when words base .. base+count-1 all lie inside a 2^addr_w memory.
  function automatic logic load_fits(input logic [BASE_W-1:0] base,
                                     input logic [CNT_W-1:0]  count,
                                     input int unsigned       addr_w);
    logic [31:0] end_v;
    logic [31:0] depth_v;
    end_v   = {16'd0, base} + {18'd0, count};
    depth_v = 32'd1 << addr_w;
    return (end_v <= depth_v);
  endfunction

endpackage

// File: rtl/program_loader_run_timer.sv
// RUN budget timer: 30-bit down-counter. A loaded value of 0 never expires
// (run until HALT); otherwise expire pulses during the last enabled cycle.
module loader_run_timer
  import program_loader_pkg::*;
(
  input  logic                clk,
  input  logic                arst_n,
  input  logic                load,
  input  logic [BUDGET_W-1:0] load_value,
  input  logic                cnt_en,
  output logic                expire
);

  logic [BUDGET_W-1:0] count_r;

  // Budget counter: load has priority, then count down while enabled, stop at 0
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count_r <= 30'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (cnt_en && (count_r != 30'd0)) begin
      count_r <= count_r - 30'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = cnt_en && (count_r == 30'd1);

endmodule

// File: rtl/program_loader.sv
// Program loader: parses host headers, streams words into instruction or
// data memory through the CPU's external write ports, and gates the CPU
// enable for a cycle budget or until HALT. All outputs are registered.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_W = 9,
  parameter int unsigned DMEM_ADDR_W = 10,
  parameter int unsigned ADDR_INC    = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        run_done,
  output logic        error
);

  localparam logic [31:0] ADDR_INC_C = 32'(ADDR_INC);

  state_e              state_r, state_s;
  op_e                 hdr_op_s;
  logic [CNT_W-1:0]    hdr_cnt_s;
  logic [BASE_W-1:0]   hdr_base_s;
  logic [BUDGET_W-1:0] hdr_budget_s;
  logic                accept_s, fits_s;
  logic [31:0]         wr_addr_s;

  logic                target_dmem_r, target_dmem_s;
  logic                discard_r, discard_s;
  logic [CNT_W-1:0]    remain_r, remain_s;
  logic [31:0]         waddr_r, waddr_s;

  logic                s_ready_r, s_ready_s;
  logic [31:0]         imem_addr_r, imem_addr_s, imem_wdata_r, imem_wdata_s;
  logic [31:0]         dmem_addr_r, dmem_addr_s, dmem_wdata_r, dmem_wdata_s;
  logic                imem_wen_r, imem_wen_s, dmem_wen_r, dmem_wen_s;
  logic                cpu_enable_r, cpu_enable_s;
  logic                busy_r, busy_s, run_done_r, run_done_s, error_r, error_s;
  logic                stop_s, timer_load_s, timer_en_s, timer_expire_s;

  assign hdr_op_s     = op_e'(s_data[HDR_OP_HI:HDR_OP_LO]);
  assign hdr_cnt_s    = s_data[HDR_CNT_HI:HDR_CNT_LO];
  assign hdr_base_s   = s_data[HDR_BASE_HI:HDR_BASE_LO];
  assign hdr_budget_s = s_data[HDR_BUDGET_HI:HDR_BUDGET_LO];
  assign accept_s     = s_valid & s_ready_r;
  assign fits_s       = load_fits(hdr_base_s, hdr_cnt_s,
                                  (hdr_op_s == OP_LOAD_DMEM) ? DMEM_ADDR_W : IMEM_ADDR_W);
  assign wr_addr_s    = waddr_r * ADDR_INC_C;

  loader_run_timer u_run_timer (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (timer_load_s),
    .load_value (hdr_budget_s),
    .cnt_en     (timer_en_s),
    .expire     (timer_expire_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_s       = state_r;
    target_dmem_s = target_dmem_r;
    discard_s     = discard_r;
    remain_s      = remain_r;
    waddr_s       = waddr_r;
    s_ready_s     = 1'b1;
    imem_addr_s   = imem_addr_r;
    imem_wdata_s  = imem_wdata_r;
    imem_wen_s    = 1'b0;
    dmem_addr_s   = dmem_addr_r;
    dmem_wdata_s  = dmem_wdata_r;
    dmem_wen_s    = 1'b0;
    run_done_s    = 1'b0;
    error_s       = error_r;
    stop_s        = 1'b0;
    timer_load_s  = 1'b0;
    timer_en_s    = (state_r == ST_RUN);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (hdr_op_s)
            OP_LOAD_IMEM, OP_LOAD_DMEM: begin
              if (hdr_cnt_s != 14'd0) begin
                // Out-of-range loads still consume their words, just without writes
                target_dmem_s = (hdr_op_s == OP_LOAD_DMEM);
                discard_s     = !fits_s;
                remain_s      = hdr_cnt_s;
                waddr_s       = {16'd0, hdr_base_s};
                error_s       = error_r | !fits_s;
                state_s       = ST_LOAD;
              end else begin
                state_s = ST_IDLE;
              end
            end
            OP_RUN: begin
              timer_load_s = 1'b1;
              state_s      = ST_RUN;
            end
            OP_HALT: begin
              state_s = ST_IDLE;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (accept_s) begin
          if (!discard_r) begin
            if (target_dmem_r) begin
              dmem_wen_s   = 1'b1;
              dmem_addr_s  = wr_addr_s;
              dmem_wdata_s = s_data;
            end else begin
              imem_wen_s   = 1'b1;
              imem_addr_s  = wr_addr_s;
              imem_wdata_s = s_data;
            end
          end else begin
            imem_wen_s = 1'b0;
          end
          waddr_s  = waddr_r + 32'd1;
          remain_s = remain_r - 14'd1;
          if (remain_r == 14'd1) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end

      ST_RUN: begin
        stop_s = timer_expire_s;
        if (accept_s) begin
          if (hdr_op_s == OP_HALT) begin
            stop_s = 1'b1;
          end else begin
            error_s = 1'b1;
          end
        end else begin
          error_s = error_r;
        end
        if (stop_s) begin
          run_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    cpu_enable_s = (state_s == ST_RUN);
    busy_s       = (state_s != ST_IDLE);
  end

  // Datapath and output registers; reset abandons any load or run
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      target_dmem_r <= 1'b0;
      discard_r     <= 1'b0;
      remain_r      <= 14'd0;
      waddr_r       <= 32'd0;
      s_ready_r     <= 1'b0;
      imem_addr_r   <= 32'd0;
      imem_wdata_r  <= 32'd0;
      imem_wen_r    <= 1'b0;
      dmem_addr_r   <= 32'd0;
      dmem_wdata_r  <= 32'd0;
      dmem_wen_r    <= 1'b0;
      cpu_enable_r  <= 1'b0;
      busy_r        <= 1'b0;
      run_done_r    <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      target_dmem_r <= target_dmem_s;
      discard_r     <= discard_s;
      remain_r      <= remain_s;
      waddr_r       <= waddr_s;
      s_ready_r     <= s_ready_s;
      imem_addr_r   <= imem_addr_s;
      imem_wdata_r  <= imem_wdata_s;
      imem_wen_r    <= imem_wen_s;
      dmem_addr_r   <= dmem_addr_s;
      dmem_wdata_r  <= dmem_wdata_s;
      dmem_wen_r    <= dmem_wen_s;
      cpu_enable_r  <= cpu_enable_s;
      busy_r        <= busy_s;
      run_done_r    <= run_done_s;
      error_r       <= error_s;
    end
  end

  assign s_ready    = s_ready_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wen   = imem_wen_r;
  assign imem_wdata = imem_wdata_r;
  assign dmem_addr  = dmem_addr_r;
  assign dmem_wen   = dmem_wen_r;
  assign dmem_wdata = dmem_wdata_r;
  assign cpu_enable = cpu_enable_r;
  assign busy       = busy_r;
  assign run_done   = run_done_r;
  assign error      = error_r;

endmodule
